// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller: forward-select
// encodings, multi-cycle sequencer states and the forwarding priority helper.
package pipe_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_BUSY = 2'b01,
    MD_DONE = 2'b10
  } md_state_e;

  // Memory-stage result is younger than writeback, so it wins when both match.
  function automatic logic [1:0] fwd_sel(
    input logic       reg_write_m,
    input logic [4:0] write_reg_m,
    input logic       reg_write_w,
    input logic [4:0] write_reg_w,
    input logic [4:0] src
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (reg_write_m && (write_reg_m != 5'd0) && (write_reg_m == src)) begin
      sel = FWD_MEM;
    end else if (reg_write_w && (write_reg_w != 5'd0) && (write_reg_w == src)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/md_sequencer.sv
// MULT/DIV residency sequencer: holds the Execute stage for MD_LATENCY-1
// cycles, then flags the single cycle in which the result is valid.
module md_sequencer
  import pipe_pkg::*;
#(
  parameter int MD_LATENCY = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic busy,
  output logic done,
  output logic stall
);

  // Number of BUSY cycles; the IDLE start cycle is the first stalled cycle.
  localparam logic [7:0] CNT_LOAD = 8'(MD_LATENCY - 2);

  md_state_e  state_q, state_d;
  logic [7:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MD_IDLE;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      MD_IDLE: begin
        if (start) begin
          cnt_d   = CNT_LOAD;
          state_d = (CNT_LOAD == 8'd0) ? MD_DONE : MD_BUSY;
        end
      end
      MD_BUSY: begin
        // Leave BUSY as the counter reaches zero so BUSY spans CNT_LOAD cycles.
        cnt_d = cnt_q - 8'd1;
        if (cnt_q <= 8'd1) begin
          state_d = MD_DONE;
        end
      end
      MD_DONE: begin
        state_d = MD_IDLE;
      end
      default: begin
        state_d = MD_IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  assign busy  = (state_q == MD_BUSY);
  assign done  = (state_q == MD_DONE);
  assign stall = busy | ((state_q == MD_IDLE) & start);

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller for the 5-stage core: forwarding selects,
// load-use / branch / MULT-DIV stalls and flushes, and a stall-cycle counter.
module hazard_unit
  import pipe_pkg::*;
#(
  parameter int MD_LATENCY = 8,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       RsD,
  input  logic [4:0]       RtD,
  input  logic [4:0]       RsE,
  input  logic [4:0]       RtE,
  input  logic [4:0]       WriteRegE,
  input  logic [4:0]       WriteRegM,
  input  logic [4:0]       WriteRegW,
  input  logic             RegWriteE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemtoRegE,
  input  logic             MemtoRegM,
  input  logic             BranchD,
  input  logic             MulDivStartE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             ForwardAD,
  output logic             ForwardBD,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             FlushE,
  output logic             FlushM,
  output logic             MdBusy,
  output logic             MdDoneE,
  output logic [CNT_W-1:0] StallCycles
);

  logic lwstall;
  logic brstall;
  logic mdstall;
  logic stall_any;

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  assign ForwardAE = fwd_sel(RegWriteM, WriteRegM, RegWriteW, WriteRegW, RsE);
  assign ForwardBE = fwd_sel(RegWriteM, WriteRegM, RegWriteW, WriteRegW, RtE);

  assign ForwardAD = (RsD != 5'd0) & (RsD == WriteRegM) & RegWriteM;
  assign ForwardBD = (RtD != 5'd0) & (RtD == WriteRegM) & RegWriteM;

  assign lwstall = MemtoRegE & ((RtE == RsD) | (RtE == RtD));
  assign brstall = BranchD &
                   ((RegWriteE & ((WriteRegE == RsD) | (WriteRegE == RtD))) |
                    (MemtoRegM & ((WriteRegM == RsD) | (WriteRegM == RtD))));

  md_sequencer #(
    .MD_LATENCY(MD_LATENCY)
  ) u_md_sequencer (
    .clk  (clk),
    .rst_n(rst_n),
    .start(MulDivStartE),
    .busy (MdBusy),
    .done (MdDoneE),
    .stall(mdstall)
  );

  assign stall_any = lwstall | brstall | mdstall;

  assign StallF = stall_any;
  assign StallD = stall_any;
  assign StallE = mdstall;
  assign FlushM = mdstall;
  // A held Execute stage must keep its instruction, so never bubble it.
  assign FlushE = (lwstall | brstall) & ~mdstall;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_any && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign StallCycles = stall_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: table of combinational vectors, then
// MULT/DIV sequencing, asynchronous reset, counter saturation and latency-2.
module tb_hazard_unit;

  logic       clk;
  logic       rst_n;
  logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic       RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, BranchD, MulDivStartE;

  logic [1:0]  fae0, fbe0, fae1, fbe1;
  logic        fad0, fbd0, sf0, sd0, se0, fe0, fm0, busy0, done0;
  logic        fad1, fbd1, sf1, sd1, se1, fe1, fm1, busy1, done1;
  logic [15:0] cnt0;
  logic [3:0]  cnt1;

  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;

  hazard_unit #(.MD_LATENCY(8), .CNT_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM), .BranchD(BranchD),
    .MulDivStartE(MulDivStartE), .ForwardAE(fae0), .ForwardBE(fbe0),
    .ForwardAD(fad0), .ForwardBD(fbd0), .StallF(sf0), .StallD(sd0), .StallE(se0),
    .FlushE(fe0), .FlushM(fm0), .MdBusy(busy0), .MdDoneE(done0), .StallCycles(cnt0)
  );

  hazard_unit #(.MD_LATENCY(2), .CNT_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM), .BranchD(BranchD),
    .MulDivStartE(MulDivStartE), .ForwardAE(fae1), .ForwardBE(fbe1),
    .ForwardAD(fad1), .ForwardBD(fbd1), .StallF(sf1), .StallD(sd1), .StallE(se1),
    .FlushE(fe1), .FlushM(fm1), .MdBusy(busy1), .MdDoneE(done1), .StallCycles(cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // exp = {ForwardAE, ForwardBE, ForwardAD, ForwardBD, StallF, StallD, StallE, FlushE, FlushM}
  typedef struct packed {
    logic [4:0]  rsd, rtd, rse, rte, wre, wrm, wrw;
    logic        rwe, rwm, rww, mte, mtm, brd;
    logic [10:0] exp;
  } vec_t;

  vec_t vecs [14];

  function automatic vec_t mkv(
    input logic [4:0] rsd, rtd, rse, rte, wre, wrm, wrw,
    input logic rwe, rwm, rww, mte, mtm, brd,
    input logic [10:0] exp
  );
    vec_t v;
    v.rsd = rsd; v.rtd = rtd; v.rse = rse; v.rte = rte;
    v.wre = wre; v.wrm = wrm; v.wrw = wrw;
    v.rwe = rwe; v.rwm = rwm; v.rww = rww; v.mte = mte; v.mtm = mtm; v.brd = brd;
    v.exp = exp;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic drive(input vec_t v);
    RsD = v.rsd; RtD = v.rtd; RsE = v.rse; RtE = v.rte;
    WriteRegE = v.wre; WriteRegM = v.wrm; WriteRegW = v.wrw;
    RegWriteE = v.rwe; RegWriteM = v.rwm; RegWriteW = v.rww;
    MemtoRegE = v.mte; MemtoRegM = v.mtm; BranchD = v.brd;
  endtask

  initial begin
    vec_t zero_v, lw_v;
    zero_v = mkv(0,0,0,0,0,0,0, 0,0,0,0,0,0, 11'b00_00_0_0_00000);
    lw_v   = mkv(9,2,0,9,0,0,0, 0,0,0,1,0,0, 11'b00_00_0_0_11010);

    //               rsd rtd rse rte wre wrm wrw rwe rwm rww mte mtm brd  exp
    vecs[0]  = zero_v;
    vecs[1]  = mkv(0, 0, 8, 0, 0, 8, 8,  0, 1, 1, 0, 0, 0, 11'b10_00_0_0_00000);
    vecs[2]  = mkv(0, 0, 8, 0, 0, 8, 8,  0, 0, 1, 0, 0, 0, 11'b01_00_0_0_00000);
    vecs[3]  = mkv(0, 0, 0, 0, 0, 0, 0,  0, 1, 1, 0, 0, 0, 11'b00_00_0_0_00000);
    vecs[4]  = mkv(0, 0, 0, 5, 0, 3, 5,  0, 1, 1, 0, 0, 0, 11'b00_01_0_0_00000);
    vecs[5]  = mkv(0, 0, 7, 5, 0, 5, 5,  0, 1, 1, 0, 0, 0, 11'b00_10_0_0_00000);
    vecs[6]  = lw_v;
    vecs[7]  = mkv(1, 6, 0, 6, 0, 0, 0,  0, 0, 0, 1, 0, 0, 11'b00_00_0_0_11010);
    vecs[8]  = mkv(1, 2, 0, 6, 0, 0, 0,  0, 0, 0, 1, 0, 0, 11'b00_00_0_0_00000);
    vecs[9]  = mkv(4, 3, 0, 0, 4, 0, 0,  1, 0, 0, 0, 0, 1, 11'b00_00_0_0_11010);
    vecs[10] = mkv(4, 3, 0, 0, 0, 4, 0,  0, 1, 0, 0, 0, 1, 11'b00_00_1_0_00000);
    vecs[11] = mkv(4, 3, 0, 0, 0, 3, 0,  0, 1, 0, 0, 1, 1, 11'b00_00_0_1_11010);
    vecs[12] = mkv(4, 3, 0, 0, 0, 3, 0,  0, 1, 0, 0, 1, 0, 11'b00_00_0_1_00000);
    vecs[13] = mkv(0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0, 0, 11'b00_00_0_0_00000);

    rst_n = 1'b0;
    MulDivStartE = 1'b0;
    drive(zero_v);
    repeat (2) @(negedge clk);
    #2;
    chk("reset_busy", 32'(busy0), 32'd0);
    chk("reset_done", 32'(done0), 32'd0);
    chk("reset_cnt",  32'(cnt0),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Combinational table; counter model follows the expected StallF bit.
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #2;
      chk($sformatf("vec%0d_outs", i),
          32'({fae0, fbe0, fad0, fbd0, sf0, sd0, se0, fe0, fm0}), 32'(vecs[i].exp));
      chk($sformatf("vec%0d_cnt", i), 32'(cnt0), 32'(exp_cnt));
      if (vecs[i].exp[4]) exp_cnt++;
    end

    // MULT/DIV with latency 8 held from cycle 0.
    @(negedge clk);
    drive(zero_v);
    MulDivStartE = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #2;
      chk($sformatf("md_cyc%0d", k),
          32'({sf0, se0, fe0, fm0, busy0, done0}),
          32'({k < 7, k < 7, 1'b0, k < 7, (k >= 1 && k <= 6), k == 7}));
      if (k == 0) chk("md_cnt_start", 32'(cnt0), 32'(exp_cnt));
      @(negedge clk);
    end
    MulDivStartE = 1'b0;
    #2;
    chk("md_after_idle", 32'({sf0, busy0, done0}), 32'd0);
    chk("md_cnt_end", 32'(cnt0), 32'(exp_cnt + 7));

    // Asynchronous reset in cycle 3 of a MULT.
    @(negedge clk);
    MulDivStartE = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_pre_busy", 32'(busy0), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_busy", 32'(busy0), 32'd0);
    chk("rst_async_cnt",  32'(cnt0),  32'd0);
    MulDivStartE = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    chk("rst_rel_stallf", 32'(sf0), 32'd0);
    @(negedge clk);
    #2;
    chk("rst_rel_state", 32'({busy0, done0, cnt0}), 32'd0);

    // 20 load-use cycles: 4-bit counter saturates, 16-bit keeps counting.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive(lw_v);
      #2;
      chk($sformatf("sat_cyc%0d", i), 32'(cnt1), 32'((i > 15) ? 15 : i));
    end
    @(negedge clk);
    drive(zero_v);
    #2;
    chk("sat_final4",  32'(cnt1), 32'd15);
    chk("sat_final16", 32'(cnt0), 32'd20);

    // Minimum latency 2: one stalled cycle, then the done cycle.
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    MulDivStartE = 1'b1;
    #2;
    chk("lat2_cyc0", 32'({se1, busy1, done1}), 32'b100);
    @(negedge clk);
    #2;
    chk("lat2_cyc1", 32'({se1, busy1, done1}), 32'b001);
    @(negedge clk);
    MulDivStartE = 1'b0;
    #2;
    chk("lat2_cyc2", 32'({se1, busy1, done1}), 32'b000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
Pipeline hazard controller for the 5-stage MIPS core. It drives the forwarding selects that the Execute stage consumes on ForwardAE/ForwardBE. It also produces the Decode-stage branch-compare forwards and the stall/flush controls for load-use, branch, and multi-cycle MULT/DIV hazards. The multi-cycle sequencer FSM and a saturating stall-cycle counter are the sequential core of the block.

Parameters:
MD_LATENCY, 8, total EX cycles for a MULT/DIV op, including the done cycle; legal range 2..255
CNT_W, 16, width of the stall-cycle performance counter

Ports:
clk  input  1  core clock, rising edge
rst_n  input  1  asynchronous active-low reset
RsD  input  5  source reg A in Decode
RtD  input  5  source reg B in Decode
RsE  input  5  source reg A in Execute
RtE  input  5  source reg B in Execute
WriteRegE  input  5  destination reg in Execute
WriteRegM  input  5  destination reg in Memory
WriteRegW  input  5  destination reg in Writeback
RegWriteE  input  1  Execute instr writes the register file
RegWriteM  input  1  Memory instr writes the register file
RegWriteW  input  1  Writeback instr writes the register file
MemtoRegE  input  1  Execute instr is a load
MemtoRegM  input  1  Memory instr is a load
BranchD  input  1  Decode instr is a branch
MulDivStartE  input  1  Execute holds a MULT/DIV
ForwardAE  output  2  SrcA select: 00 RD1, 01 ResultW, 10 ALUOutM
ForwardBE  output  2  SrcB select: same encoding as ForwardAE
ForwardAD  output  1  Decode compare A takes ALUOutM
ForwardBD  output  1  Decode compare B takes ALUOutM
StallF  output  1  hold PC
StallD  output  1  hold IF/ID register
StallE  output  1  hold ID/EX register
FlushE  output  1  bubble into ID/EX
FlushM  output  1  bubble into EX/MEM
MdBusy  output  1  sequencer in BUSY state
MdDoneE  output  1  MULT/DIV result valid this cycle
StallCycles  output  CNT_W  saturating count of cycles with StallF=1

Behaviour:
- Forwarding (combinational):
  - ForwardAE = 10 if RegWriteM & WriteRegM!=0 & WriteRegM==RsE.
  - Otherwise ForwardAE = 01 if RegWriteW & WriteRegW!=0 & WriteRegW==RsE.
  - Otherwise ForwardAE = 00.
  - M beats W when both match.
  - ForwardBE uses the same rules with RtE.
  - Encoding 11 is never driven.
- ForwardAD = RsD!=0 & RsD==WriteRegM & RegWriteM. ForwardBD is the same with RtD.
- lwstall = MemtoRegE & (RtE==RsD | RtE==RtD).
- brstall = BranchD & ((RegWriteE & (WriteRegE==RsD | WriteRegE==RtD)) | (MemtoRegM & (WriteRegM==RsD | WriteRegM==RtD))).
- Sequencer FSM, states IDLE, BUSY, DONE; 8-bit down-counter cnt:
  - IDLE -> BUSY on MulDivStartE; cnt loads MD_LATENCY-2.
  - BUSY: cnt decrements each cycle; at cnt==0 the next state is DONE.
  - DONE -> IDLE unconditionally; MdDoneE=1 for exactly this cycle.
  - MulDivStartE is ignored in BUSY and DONE; the held instruction keeps it high.
- mdstall = (state==BUSY) | (state==IDLE & MulDivStartE).
- Outputs:
  - StallF = StallD = lwstall | brstall | mdstall.
  - StallE = mdstall.
  - FlushM = mdstall.
  - FlushE = (lwstall | brstall) & ~mdstall. An MD stall freezes E, so E is never flushed while held.
- Total EX residency of a MULT/DIV is MD_LATENCY cycles: MD_LATENCY-1 stalled cycles plus the DONE cycle, in which it advances.
- StallCycles increments on every cycle with StallF=1 and saturates at all-ones; it has no wrap.
- Reset (asynchronous, any time including mid-BUSY):
  - state=IDLE, cnt=0, StallCycles=0, MdBusy=0, MdDoneE=0.
  - Combinational outputs follow their inputs; no stall is generated from sequencer state during reset.

Decomposition:
- Shared package pipe_pkg:
  - forward-select constants FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10;
  - sequencer state encoding.
- One natural sub-module, md_sequencer: FSM, cnt, MdBusy, MdDoneE, mdstall. The top level keeps forwarding, lwstall/brstall and StallCycles.

Test Plan:
- RegWriteM=1, WriteRegM=8, RegWriteW=1, WriteRegW=8, RsE=8 -> ForwardAE=10; then RegWriteM=0 -> ForwardAE=01; WriteReg=0 with RsE=0 -> ForwardAE=00.
- Load-use: MemtoRegE=1, RtE=9, RsD=9 -> StallF=StallD=FlushE=1, StallE=0, StallCycles +1.
- Branch: BranchD=1, RsD=4, RegWriteE=1, WriteRegE=4 -> stall. Next cycle MemtoRegM=0, WriteRegM=4, RegWriteM=1 -> no stall, ForwardAD=1.
- MD_LATENCY=8, MulDivStartE held from cycle 0:
  - StallE=1 for cycles 0-6;
  - MdDoneE=1 only in cycle 7, then IDLE;
  - StallCycles reaches 7.
- Assert rst_n=0 at cycle 3 of a MULT -> asynchronously MdBusy=0 and StallCycles=0; after release with MulDivStartE=0, StallF=0.
- CNT_W=4 with 20 continuous lwstall cycles -> StallCycles saturates at 15.
